// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - time-multiplexed seven-segment display scan driver
//
// Captures a packed multi-digit hex value into shadow registers and shows one
// digit at a time on active-low segment lines. Each digit owns a slot of
// REFRESH_DIV clocks; the first clock of every slot is dead (nothing driven)
// so the previous digit's segments never ghost onto the next anode. Supports
// per-digit blanking, decimal points and leading-zero suppression.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   value    packed hex digits, digit i = value[4i+3:4i], digit 0 rightmost
//   dp       per-digit decimal point request (1 = lit)
//   blank    per-digit force-dark (1 = dark)
//   lz_en    leading-zero suppression enable
//   load     copies value/dp/blank/lz_en into the shadow registers
//   seg_n    active-low segments, bit0 = a ... bit6 = g
//   dp_n     active-low decimal point
//   an_n     active-low digit enables, at most one low

module ssd_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   sh_value;
  logic [DIGITS-1:0]     sh_dp;
  logic [DIGITS-1:0]     sh_blank;
  logic                  sh_lz;

  logic [CW-1:0]         cnt_nxt;
  logic [IW-1:0]         idx_nxt;
  logic [4*DIGITS-1:0]   value_nxt;
  logic [DIGITS-1:0]     dp_nxt;
  logic [DIGITS-1:0]     blank_nxt;
  logic                  lz_nxt;

  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_sup;
  logic                  all_zero;

  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [DIGITS-1:0]     an_d;

  // Gfedcba active-high pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Next-state values; outputs are decoded from these so that a load or a
  // slot wrap on this edge is already reflected in what gets registered.
  always_comb begin
    cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    idx_nxt = idx;
    if (cnt == CNT_LAST) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    value_nxt = load ? value : sh_value;
    dp_nxt    = load ? dp    : sh_dp;
    blank_nxt = load ? blank : sh_blank;
    lz_nxt    = load ? lz_en : sh_lz;
  end

  // Walk from the most significant digit down; all_zero stays set while every
  // digit from the top down to i is zero, which is exactly the suppression
  // condition for digit i. Digit 0 is exempt so zero still shows "0".
  always_comb begin
    all_zero  = 1'b1;
    cur_digit = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_sup   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (value_nxt[4*i +: 4] == 4'h0);
      if (idx_nxt == IW'(i)) begin
        cur_digit = value_nxt[4*i +: 4];
        cur_dp    = dp_nxt[i];
        cur_blank = blank_nxt[i];
        cur_sup   = lz_nxt & all_zero & (i != 0);
      end
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (cnt_nxt != '0) begin
      for (int i = 0; i < DIGITS; i++) begin
        an_d[i] = (idx_nxt != IW'(i));
      end
      // A dark digit keeps its anode so the slot timing is unchanged.
      if (!(cur_blank || cur_sup)) begin
        seg_d = ~hex7(cur_digit);
        dp_d  = ~cur_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      idx      <= '0;
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      sh_lz    <= 1'b0;
      an_n     <= '1;
      seg_n    <= 7'h7F;
      dp_n     <= 1'b1;
    end else begin
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      sh_value <= value_nxt;
      sh_dp    <= dp_nxt;
      sh_blank <= blank_nxt;
      sh_lz    <= lz_nxt;
      an_n     <= an_d;
      seg_n    <= seg_d;
      dp_n     <= dp_d;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - directed self-checking bench for ssd_scan_driver
//
// Runs the driver with DIGITS=4, REFRESH_DIV=4. The bench keeps its own slot
// position (bcnt/bidx) and a per-digit table of hand-computed expected
// segment/dp values, and checks every output on the falling clock edge.

module tb_ssd_scan_driver;

  localparam int DIGITS = 4;
  localparam int RDIV   = 4;

  logic                clk;
  logic                reset_n;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic                lz_en;
  logic                load;
  logic [6:0]          seg_n;
  logic                dp_n;
  logic [DIGITS-1:0]   an_n;

  int n_checks = 0;
  int n_fail   = 0;
  int bcnt     = 0;
  int bidx     = 0;

  logic [6:0] exp_seg [DIGITS];
  logic       exp_dp  [DIGITS];

  // Inverted (active-low) segment patterns for hex 0..F.
  logic [6:0] inv_tab [16];

  ssd_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .value   (value),
    .dp      (dp),
    .blank   (blank),
    .lz_en   (lz_en),
    .load    (load),
    .seg_n   (seg_n),
    .dp_n    (dp_n),
    .an_n    (an_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; sample point is the falling edge.
  task automatic tick();
    @(negedge clk);
    bcnt = (bcnt + 1) % RDIV;
    if (bcnt == 0) bidx = (bidx + 1) % DIGITS;
  endtask

  task automatic check_now(input string tag);
    logic [7:0] ea, es, ed;
    if (bcnt == 0) begin
      ea = 8'h0F;
      es = 8'h7F;
      ed = 8'h01;
    end else begin
      ea = 8'h0F & ~(8'h01 << bidx);
      es = {1'b0, exp_seg[bidx]};
      ed = {7'b0, exp_dp[bidx]};
    end
    chk($sformatf("%s an_n c%0d i%0d", tag, bcnt, bidx), {4'b0, an_n}, ea);
    chk($sformatf("%s seg_n c%0d i%0d", tag, bcnt, bidx), {1'b0, seg_n}, es);
    chk($sformatf("%s dp_n c%0d i%0d", tag, bcnt, bidx), {7'b0, dp_n}, ed);
  endtask

  task automatic run_check(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check_now(tag);
    end
  endtask

  task automatic set_exp(input logic [6:0] s3, s2, s1, s0, input logic [3:0] dpn);
    exp_seg[3] = s3; exp_seg[2] = s2; exp_seg[1] = s1; exp_seg[0] = s0;
    for (int k = 0; k < DIGITS; k++) exp_dp[k] = dpn[k];
  endtask

  // Present inputs, pulse load for one edge, then check that first cycle.
  task automatic do_load(input string tag, input logic [15:0] v, input logic [3:0] d,
                         input logic [3:0] b, input logic lz);
    value = v; dp = d; blank = b; lz_en = lz; load = 1'b1;
    tick();
    load = 1'b0;
    value = 16'hDEAD; dp = 4'hF; blank = 4'hF; lz_en = 1'b1;
    check_now(tag);
  endtask

  initial begin
    inv_tab[0]  = 7'h40; inv_tab[1]  = 7'h79; inv_tab[2]  = 7'h24; inv_tab[3]  = 7'h30;
    inv_tab[4]  = 7'h19; inv_tab[5]  = 7'h12; inv_tab[6]  = 7'h02; inv_tab[7]  = 7'h78;
    inv_tab[8]  = 7'h00; inv_tab[9]  = 7'h10; inv_tab[10] = 7'h08; inv_tab[11] = 7'h03;
    inv_tab[12] = 7'h46; inv_tab[13] = 7'h21; inv_tab[14] = 7'h06; inv_tab[15] = 7'h0E;

    reset_n = 1'b0; value = '0; dp = '0; blank = '0; lz_en = 1'b0; load = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset an_n", {4'b0, an_n}, 8'h0F);
    chk("reset seg_n", {1'b0, seg_n}, 8'h7F);
    chk("reset dp_n", {7'b0, dp_n}, 8'h01);

    // First edge after release shows digit 0 of an all-zero shadow
    reset_n = 1'b1;
    bcnt = 0; bidx = 0;
    set_exp(7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
    tick();
    check_now("first");

    // Scan order with 0x1234
    set_exp(7'h79, 7'h24, 7'h30, 7'h19, 4'hF);
    do_load("scan", 16'h1234, 4'h0, 4'h0, 1'b0);
    run_check("scan", 18);

    // Decode sweep on digit 0
    for (int d = 0; d < 16; d++) begin
      set_exp(7'h40, 7'h40, 7'h40, inv_tab[d], 4'hF);
      do_load($sformatf("dec%0d", d), {12'h000, 4'(d)}, 4'h0, 4'h0, 1'b0);
      run_check($sformatf("dec%0d", d), 16);
    end

    // Leading-zero suppression
    set_exp(7'h7F, 7'h7F, 7'h12, 7'h40, 4'hF);
    do_load("lz0050", 16'h0050, 4'h0, 4'h0, 1'b1);
    run_check("lz0050", 16);
    set_exp(7'h7F, 7'h7F, 7'h7F, 7'h40, 4'hF);
    do_load("lz0000", 16'h0000, 4'h0, 4'h0, 1'b1);
    run_check("lz0000", 16);
    set_exp(7'h40, 7'h40, 7'h12, 7'h40, 4'hF);
    do_load("nolz0050", 16'h0050, 4'h0, 4'h0, 1'b0);
    run_check("nolz0050", 16);
    set_exp(7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
    do_load("nolz0000", 16'h0000, 4'h0, 4'h0, 1'b0);
    run_check("nolz0000", 16);

    // Blank and decimal point; a dp request on a blanked digit stays dark
    set_exp(7'h00, 7'h7F, 7'h00, 7'h00, 4'b1101);
    do_load("blkdp", 16'h8888, 4'b0110, 4'b0100, 1'b0);
    run_check("blkdp", 16);

    // Load coinciding with the wrap out of digit 0
    set_exp(7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
    do_load("prewrap", 16'h0000, 4'h0, 4'h0, 1'b0);
    while (!(bcnt == 3 && bidx == 0)) begin
      tick();
      check_now("prewrap");
    end
    set_exp(7'h0E, 7'h0E, 7'h0E, 7'h0E, 4'hF);
    do_load("wrapload", 16'hFFFF, 4'h0, 4'h0, 1'b0);
    tick();
    chk("wrapload digit1 first seg_n", {1'b0, seg_n}, 8'h0E);
    chk("wrapload digit1 first an_n", {4'b0, an_n}, 8'h0D);
    run_check("wrapload", 14);

    // Asynchronous reset mid-slot
    while (!(bcnt == 2 && bidx == 2)) begin
      tick();
      check_now("premid");
    end
    reset_n = 1'b0;
    #1;
    chk("midreset an_n", {4'b0, an_n}, 8'h0F);
    chk("midreset seg_n", {1'b0, seg_n}, 8'h7F);
    chk("midreset dp_n", {7'b0, dp_n}, 8'h01);
    @(negedge clk);
    reset_n = 1'b1;
    bcnt = 0; bidx = 0;
    set_exp(7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
    run_check("restart", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
